// File: rtl/system_tb_sequencer.sv
// Bench-side master for the system memory port: preloads a program image from a valid/ready
// stream, then dumps a memory range to another one. Optional macro DUMP_SKIP_ZERO_EN drops zero words from dumps.
module system_tb_sequencer #(
  parameter int ACC_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start_load,
  input  logic             start_dump,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic             tbCTRL,
  output logic             WEN,
  output logic             REN,
  output logic [31:0]      addr,
  output logic [31:0]      store,
  input  logic [31:0]      load,
  input  logic             halt
);
  localparam int HOLD_W = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACC_LAT - 1);

  typedef enum logic [2:0] {IDLE, LD_WAIT, LD_WR, DP_RD, DP_OUT, FIN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [HOLD_W-1:0] hold;
  logic              lastWord;
  logic              holdDone;
  logic              skipWord;
  logic [31:0]       nextAddr;

  assign lastWord = (count == CNT_W'(1));
  assign holdDone = (hold == '0);
  assign nextAddr = addr + 32'd4;

`ifdef DUMP_SKIP_ZERO_EN
  assign skipWord = (load == 32'd0);
`else
  assign skipWord = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      count     <= '0;
      hold      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      halted    <= 1'b0;
      tbCTRL    <= 1'b0;
      WEN       <= 1'b0;
      REN       <= 1'b0;
      addr      <= '0;
      store     <= '0;
    end else begin
      halted <= halt;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_load || start_dump) begin
            addr   <= {base_addr[31:2], 2'b00};
            count  <= word_count;
            busy   <= 1'b1;
            tbCTRL <= 1'b1;
            if (word_count == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (start_load) begin
              state    <= LD_WAIT;
              in_ready <= 1'b1;
            end else begin
              state <= DP_RD;
              REN   <= 1'b1;
              hold  <= HOLD_LAST;
            end
          end
        end

        LD_WAIT: begin
          if (in_valid) begin
            store    <= in_data;
            in_ready <= 1'b0;
            WEN      <= 1'b1;
            hold     <= HOLD_LAST;
            state    <= LD_WR;
          end
        end

        // Write strobe, address and data held for ACC_LAT cycles before stepping on.
        LD_WR: begin
          if (!holdDone) begin
            hold <= hold - HOLD_W'(1);
          end else begin
            WEN   <= 1'b0;
            addr  <= nextAddr;
            count <= count - CNT_W'(1);
            if (lastWord) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state    <= LD_WAIT;
              in_ready <= 1'b1;
            end
          end
        end

        // load is captured on the last held read cycle.
        DP_RD: begin
          if (!holdDone) begin
            hold <= hold - HOLD_W'(1);
          end else if (skipWord) begin
            addr  <= nextAddr;
            count <= count - CNT_W'(1);
            hold  <= HOLD_LAST;
            if (lastWord) begin
              REN   <= 1'b0;
              state <= FIN;
              done  <= 1'b1;
            end
          end else begin
            out_data  <= load;
            out_addr  <= addr;
            out_valid <= 1'b1;
            REN       <= 1'b0;
            state     <= DP_OUT;
          end
        end

        DP_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            addr      <= nextAddr;
            count     <= count - CNT_W'(1);
            if (lastWord) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= DP_RD;
              REN   <= 1'b1;
              hold  <= HOLD_LAST;
            end
          end
        end

        FIN: begin
          busy   <= 1'b0;
          tbCTRL <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_system_tb_sequencer.sv
// Randomised bench for system_tb_sequencer: emulated system memory, stream producer/consumer,
// and a transaction-level reference model checked every cycle by one monitor process.
module tb_system_tb_sequencer;
  localparam int ACC_LAT = 2;
  localparam int CNT_W   = 16;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             start_load, start_dump;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_addr, out_data;
  logic             out_ready;
  logic             busy, done, halted, tbCTRL, WEN, REN;
  logic [31:0]      addr, store, load;
  logic             halt;

  always #5 CLK = ~CLK;

  system_tb_sequencer #(.ACC_LAT(ACC_LAT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .start_load(start_load), .start_dump(start_dump),
    .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .halted(halted), .tbCTRL(tbCTRL),
    .WEN(WEN), .REN(REN), .addr(addr), .store(store), .load(load), .halt(halt)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Emulated system memory; writes commit mid-cycle, reads are combinational while REN.
  logic [31:0] sysMem [2048];
  assign load = REN ? sysMem[addr[12:2]] : 32'hDEADBEEF;
  initial begin
    for (int i = 0; i < 2048; i++) sysMem[i] = 32'h0;
    forever begin
      @(negedge CLK);
      if (WEN) sysMem[addr[12:2]] = store;
    end
  end

  initial begin
    halt = 1'b0;
    forever begin
      @(posedge CLK); #1;
      halt = 1'($urandom_range(0, 1));
    end
  end

  // Reference model: byte address -> word, written only by completed preloads.
  logic [31:0] refMem [bit [31:0]];
  function automatic logic [31:0] refRd(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : 32'h0;
  endfunction

  logic [31:0] expWrA[$], expWrD[$], expOutA[$], expOutD[$];
  logic [31:0] obsWrA[$], obsWrD[$], obsA[$], obsD[$];
  logic [31:0] litA[$], litD[$], ldWords[$];

  // Output stream consumer.
  int cIdx = 0, cStallIdx = -1, cStallLeft = 0;
  bit cRand = 1'b0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (out_valid && cIdx == cStallIdx && cStallLeft > 0) begin
        out_ready = 1'b0;
        cStallLeft--;
      end else if (cRand) out_ready = ($urandom_range(0, 9) < 7);
      else out_ready = 1'b1;
      if (out_valid && out_ready) cIdx++;
    end
  end

  // Monitor: every-cycle protocol checks and transaction comparison against the model.
  int wenLen = 0, renLen = 0, doneCount = 0, renTotal = 0;
  logic [31:0] wenA, wenD, holdA, holdD;
  logic holdValid = 1'b0, prevDone = 1'b0, prevHalt = 1'b0, prevNrst = 1'b0;
  initial begin
    forever begin
      @(negedge CLK);
      chk("halted_delay", 32'(halted), 32'(prevNrst & prevHalt));
      if (!nRST) begin
        wenLen = 0; renLen = 0; holdValid = 1'b0; prevDone = 1'b0;
      end else begin
        chk("wen_ren_exclusive", 32'(WEN & REN), 32'h0);
        chk("busy_eq_tbctrl", 32'(busy), 32'(tbCTRL));
        if (!busy) chk("idle_quiet", 32'({WEN, REN, in_ready, out_valid, done}), 32'h0);
        chk("done_one_cycle", 32'(done & prevDone), 32'h0);
        if (done) doneCount++;
        prevDone = done;
        if (WEN) begin
          if (wenLen == 0) begin wenA = addr; wenD = store; end
          else begin
            chk("wen_addr_stable", addr, wenA);
            chk("wen_store_stable", store, wenD);
          end
          wenLen++;
        end else if (wenLen > 0) begin
          chk("wen_length", 32'(wenLen), 32'(ACC_LAT));
          obsWrA.push_back(wenA); obsWrD.push_back(wenD);
          if (expWrA.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL write_unexpected: got write %08h=%08h expected none", wenA, wenD);
          end else begin
            chk("write_addr", wenA, expWrA.pop_front());
            chk("write_data", wenD, expWrD.pop_front());
          end
          wenLen = 0;
        end
        if (REN) begin renLen++; renTotal++; end
        else if (renLen > 0) begin
`ifdef DUMP_SKIP_ZERO_EN
          chk("ren_length_multiple", 32'(renLen % ACC_LAT), 32'h0);
`else
          chk("ren_length", 32'(renLen), 32'(ACC_LAT));
`endif
          renLen = 0;
        end
        if (holdValid) begin
          chk("out_valid_held", 32'(out_valid), 32'h1);
          chk("out_addr_held", out_addr, holdA);
          chk("out_data_held", out_data, holdD);
        end
        if (out_valid && out_ready) begin
          obsA.push_back(out_addr); obsD.push_back(out_data);
          if (expOutA.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL out_unexpected: got %08h@%08h expected none", out_data, out_addr);
          end else begin
            chk("out_addr", out_addr, expOutA.pop_front());
            chk("out_data", out_data, expOutD.pop_front());
          end
        end
        holdValid = out_valid && !out_ready;
        holdA = out_addr; holdD = out_data;
      end
      prevHalt = halt;
      prevNrst = nRST;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic waitDone(input string name, output int waited);
    waited = 0;
    while (!done && waited < 3000) begin tick(); waited++; end
    chk(name, 32'(done), 32'h1);
  endtask

  task automatic feedWord(input logic [31:0] w, input int gap);
    bit hs;
    hs = 1'b0;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1; in_data = w;
    for (int t = 0; t < 500 && !hs; t++) begin
      @(negedge CLK);
      hs = in_ready;
      tick();
    end
    chk("in_handshake", 32'(hs), 32'h1);
    in_valid = 1'b0; in_data = $urandom;
  endtask

  task automatic doLoad(input logic [31:0] base, input int gapMax);
    int n, w, d0;
    n = ldWords.size();
    d0 = doneCount;
    obsWrA.delete(); obsWrD.delete();
    for (int i = 0; i < n; i++) begin
      expWrA.push_back(base + 32'(4 * i)); expWrD.push_back(ldWords[i]);
    end
    base_addr = base | 32'($urandom_range(0, 3)); word_count = CNT_W'(n);
    start_load = 1'b1; tick(); start_load = 1'b0; base_addr = $urandom;
    for (int i = 0; i < n; i++) feedWord(ldWords[i], $urandom_range(0, gapMax));
    waitDone("load_done_seen", w);
    tick();
    chk("load_tbctrl_after", 32'(tbCTRL), 32'h0);
    chk("load_busy_after", 32'(busy), 32'h0);
    chk("load_done_pulses", 32'(doneCount - d0), 32'h1);
    chk("load_writes_left", 32'(expWrA.size()), 32'h0);
    for (int i = 0; i < n; i++) refMem[base + 32'(4 * i)] = ldWords[i];
  endtask

  task automatic doDump(input logic [31:0] base, input int n, input int stallIdx, input bit rnd);
    int w, d0;
    logic [31:0] a, d;
    d0 = doneCount;
    obsA.delete(); obsD.delete();
    for (int i = 0; i < n; i++) begin
      a = base + 32'(4 * i); d = refRd(a);
`ifdef DUMP_SKIP_ZERO_EN
      if (d != 32'h0) begin expOutA.push_back(a); expOutD.push_back(d); end
`else
      expOutA.push_back(a); expOutD.push_back(d);
`endif
    end
    cIdx = 0; cStallIdx = stallIdx; cStallLeft = 3; cRand = rnd;
    base_addr = base | 32'($urandom_range(0, 3)); word_count = CNT_W'(n);
    start_dump = 1'b1; tick(); start_dump = 1'b0; base_addr = $urandom;
    waitDone("dump_done_seen", w);
    tick();
    chk("dump_tbctrl_after", 32'(tbCTRL), 32'h0);
    chk("dump_done_pulses", 32'(doneCount - d0), 32'h1);
    chk("dump_outputs_left", 32'(expOutA.size()), 32'h0);
  endtask

  // Compare observed writes (sel=0) or dumped words (sel=1) against hand-written literals.
  task automatic chkLit(input string name, input bit sel);
    int n;
    n = sel ? obsA.size() : obsWrA.size();
    chk({name, "_count"}, 32'(n), 32'(litA.size()));
    for (int i = 0; i < litA.size() && i < n; i++) begin
      chk({name, "_addr"}, sel ? obsA[i] : obsWrA[i], litA[i]);
      if (i < litD.size()) chk({name, "_data"}, sel ? obsD[i] : obsWrD[i], litD[i]);
    end
  endtask

  initial begin
    int w, d0, r0, n, dn;
    logic [31:0] b, db;
    nRST = 1'b0; start_load = 1'b0; start_dump = 1'b0; base_addr = 32'h0;
    word_count = '0; in_valid = 1'b0; in_data = 32'h0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tbctrl", 32'(tbCTRL), 32'h0);
    chk("rst_wen_ren", 32'({WEN, REN}), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_store", store, 32'h0);
    nRST = 1'b1;
    tick();

    ldWords = '{32'hA5A5_0001, 32'hB0B0_0002, 32'hC3C3_0003};
    doLoad(32'h100, 3);
    litA = '{32'h100, 32'h104, 32'h108};
    litD = '{32'hA5A5_0001, 32'hB0B0_0002, 32'hC3C3_0003};
    chkLit("preload_lit", 1'b0);

    ldWords = '{32'h11, 32'h22, 32'h33};
    doLoad(32'hFFFF_FFF8, 1);
    litA = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    litD = '{32'h11, 32'h22, 32'h33};
    chkLit("wrap_write_lit", 1'b0);
    doDump(32'hFFFF_FFF8, 3, -1, 1'b0);
    chkLit("wrap_dump_lit", 1'b1);

    ldWords = '{32'd1, 32'd0, 32'd7, 32'd9};
    doLoad(32'h0, 2);
    doDump(32'h0, 4, 2, 1'b0);
`ifdef DUMP_SKIP_ZERO_EN
    litA = '{32'h0, 32'h8, 32'hC};
    litD = '{32'd1, 32'd7, 32'd9};
`else
    litA = '{32'h0, 32'h4, 32'h8, 32'hC};
    litD = '{32'd1, 32'd0, 32'd7, 32'd9};
`endif
    chkLit("dump_lit", 1'b1);

    // Zero-length transfers finish immediately without touching memory.
    r0 = renTotal;
    base_addr = 32'h40; word_count = '0;
    start_dump = 1'b1; tick(); start_dump = 1'b0;
    waitDone("zero_dump_done", w);
    chk("zero_dump_latency", 32'(w), 32'h0);
    tick();
    chk("zero_dump_tbctrl", 32'(tbCTRL), 32'h0);
    chk("zero_dump_no_ren", 32'(renTotal - r0), 32'h0);
    ldWords.delete();
    doLoad(32'h80, 0);

    // Reset during a write burst aborts silently.
    d0 = doneCount;
    base_addr = 32'h200; word_count = CNT_W'(5);
    start_load = 1'b1; tick(); start_load = 1'b0;
    feedWord(32'hDEAD_0200, 0);
    for (int t = 0; t < 50 && !WEN; t++) tick();
    chk("abort_wen_active", 32'(WEN), 32'h1);
    nRST = 1'b0;
    tick();
    chk("abort_wen", 32'(WEN), 32'h0);
    chk("abort_tbctrl", 32'(tbCTRL), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    nRST = 1'b1;
    tick(); tick();
    chk("abort_no_done_pulse", 32'(doneCount - d0), 32'h0);
    ldWords = '{32'h3030_3030};
    doLoad(32'h300, 1);

    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 8);
      b = 32'h1000 + 32'($urandom_range(0, 48)) * 32'd4;
      ldWords.delete();
      for (int i = 0; i < n; i++) ldWords.push_back(($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom));
      doLoad(b, 3);
      dn = $urandom_range(1, 10);
      db = 32'h1000 + 32'($urandom_range(0, 56)) * 32'd4;
      doDump(db, dn, $urandom_range(0, dn - 1), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
